// File: rtl/shared_resource_rr.sv
// NUM_CH-way round-robin arbiter with flush priority feeding a registered, backpressured
// output stage. Define SHARED_RES_STATS_EN to add saturating stall/grant counters.
module shared_resource_rr #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH-1:0]        in_flush,
    input  logic                     out_ready,
    output logic [NUM_CH-1:0]        grant,
    output logic [NUM_CH-1:0]        out_valid,
    output logic [NUM_CH-1:0]        out_flush,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     global_stall
`ifdef SHARED_RES_STATS_EN
    ,
    output logic [STAT_W-1:0]        stall_cycles,
    output logic [NUM_CH*STAT_W-1:0] grant_count
`endif
);
    localparam int unsigned PTR_W = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 16 || DATA_W < 1 || STAT_W < 1) begin : g_param_check
        $error("shared_resource_rr: unsupported parameter set");
    end

    logic [PTR_W-1:0]         rr_ptr;
    logic [PTR_W-1:0]         next_ptr;
    logic [PTR_W-1:0]         sel;
    logic [PTR_W-1:0]         grant_idx;
    logic                     grant_any;
    logic                     accept;
    logic [NUM_CH-1:0]        flush_req;
    logic [NUM_CH-1:0]        pick_mask;
    logic [NUM_CH*DATA_W-1:0] lane_data;

    // Flush requests, when present, replace the normal request set for this cycle;
    // the same cyclic scan from rr_ptr serves both passes.
    always_comb begin
        accept    = ~|out_valid | out_ready;
        flush_req = in_valid & in_flush;
        pick_mask = (|flush_req) ? flush_req : in_valid;
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        sel       = '0;
        if (reset && accept) begin
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                sel = PTR_W'((32'(rr_ptr) + k) % NUM_CH);
                if (!grant_any && pick_mask[sel]) begin
                    grant_any  = 1'b1;
                    grant[sel] = 1'b1;
                    grant_idx  = sel;
                end
            end
        end
        global_stall = reset & (|(in_valid & ~grant));
    end

    always_comb begin
        next_ptr = rr_ptr;
        if (grant_any) begin
            next_ptr = (grant_idx == PTR_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        lane_data = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                lane_data[c*DATA_W +: DATA_W] = in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr    <= '0;
            out_valid <= '0;
            out_flush <= '0;
            out_data  <= '0;
        end else begin
            rr_ptr <= next_ptr;
            if (accept) begin
                out_valid <= grant;
                out_flush <= grant & in_flush;
                out_data  <= lane_data;
            end
        end
    end

`ifdef SHARED_RES_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= '0;
            grant_count  <= '0;
        end else begin
            if (global_stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (grant[c] && grant_count[c*STAT_W +: STAT_W] != '1) begin
                    grant_count[c*STAT_W +: STAT_W] <= grant_count[c*STAT_W +: STAT_W] + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_shared_resource_rr.sv
// Bench for shared_resource_rr (4 channels x 32 bits): directed vector table, hand-written
// backpressure/data sequences, and a randomized run against a reference model.
module tb_shared_resource_rr;
`ifdef SHARED_RES_STATS_EN
    localparam int unsigned SW = 4;
`else
    localparam int unsigned SW = 16;
`endif

    logic         clk;
    logic         reset;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_flush;
    logic         out_ready;
    logic [3:0]   grant;
    logic [3:0]   out_valid;
    logic [3:0]   out_flush;
    logic [127:0] out_data;
    logic         global_stall;
`ifdef SHARED_RES_STATS_EN
    logic [SW-1:0]   stall_cycles;
    logic [4*SW-1:0] grant_count;
`endif

    shared_resource_rr #(.NUM_CH(4), .DATA_W(32), .STAT_W(SW)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_flush(in_flush), .out_ready(out_ready), .grant(grant),
        .out_valid(out_valid), .out_flush(out_flush), .out_data(out_data),
        .global_stall(global_stall)
`ifdef SHARED_RES_STATS_EN
        , .stall_cycles(stall_cycles), .grant_count(grant_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic       rst;
        logic [3:0] v;
        logic [3:0] f;
        logic       rdy;
        logic [3:0] g;
        logic       st;
        logic [3:0] ov;
        logic [3:0] of;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] v, input logic [3:0] f,
                         input logic rd, input logic [127:0] d);
        reset = r; in_valid = v; in_flush = f; out_ready = rd; in_data = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] lanes_of(input logic [3:0] mask);
        logic [127:0] r;
        r = '0;
        for (int unsigned c = 0; c < 4; c++)
            if (mask[c]) r[c*32 +: 32] = 32'hC0DE_0000 | 32'(c);
        return r;
    endfunction

    // Eligible channel nearest to ptr in cyclic order; flush requests win when present.
    function automatic int pick(input logic [3:0] v, input logic [3:0] f, input int unsigned ptr);
        logic [3:0]  elig;
        int          best;
        int unsigned best_d;
        int unsigned d;
        elig   = (|(v & f)) ? (v & f) : v;
        best   = -1;
        best_d = 99;
        for (int unsigned c = 0; c < 4; c++) begin
            d = (c + 4 - ptr) % 4;
            if (elig[c] && d < best_d) begin
                best_d = d;
                best   = int'(c);
            end
        end
        return best;
    endfunction

    // reference model state
    int unsigned m_ptr;
    bit          m_has;
    int unsigned m_ch;
    logic        m_fl;
    logic [31:0] m_data;
    int unsigned m_stall;
    int unsigned m_gcnt[4];
    localparam int unsigned SAT = (1 << SW) - 1;

    task automatic model_reset();
        m_ptr = 0; m_has = 0; m_ch = 0; m_fl = 0; m_data = '0; m_stall = 0;
        for (int unsigned c = 0; c < 4; c++) m_gcnt[c] = 0;
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] f, input logic rd,
                       input logic [3:0] g, input logic st, input logic [3:0] ov, input logic [3:0] of);
        tbl.push_back('{r, v, f, rd, g, st, ov, of});
    endtask

    initial begin
        logic [127:0] d;
        logic [3:0]   eg;
        logic         est;
        logic         acc;
        int           c;
        logic [3:0]   rv, rf;
        logic         rr, rrdy;

        // reset, rotation, flush priority, backpressure, empty-stage accept, reset discard
        for (int unsigned i = 0; i < 3; i++) add(0, 4'hF, 4'h0, 1, 4'h0, 0, 4'h0, 4'h0);
        for (int unsigned i = 0; i < 2; i++) begin
            add(1, 4'hF, 4'h0, 1, 4'h1, 1, 4'h1, 4'h0);
            add(1, 4'hF, 4'h0, 1, 4'h2, 1, 4'h2, 4'h0);
            add(1, 4'hF, 4'h0, 1, 4'h4, 1, 4'h4, 4'h0);
            add(1, 4'hF, 4'h0, 1, 4'h8, 1, 4'h8, 4'h0);
        end
        add(1, 4'h6, 4'h4, 1, 4'h4, 1, 4'h4, 4'h4);
        add(1, 4'h2, 4'h0, 1, 4'h2, 0, 4'h2, 4'h0);
        add(1, 4'h1, 4'h0, 1, 4'h1, 0, 4'h1, 4'h0);
        for (int unsigned i = 0; i < 4; i++) add(1, 4'h2, 4'h0, 0, 4'h0, 1, 4'h1, 4'h0);
        add(1, 4'h2, 4'h0, 1, 4'h2, 0, 4'h2, 4'h0);
        add(1, 4'h0, 4'h0, 1, 4'h0, 0, 4'h0, 4'h0);
        add(1, 4'h4, 4'h0, 0, 4'h4, 0, 4'h4, 4'h0);
        add(1, 4'h1, 4'hA, 1, 4'h1, 0, 4'h1, 4'h0);
        add(1, 4'hF, 4'h9, 1, 4'h8, 1, 4'h8, 4'h8);
        add(1, 4'hF, 4'h9, 0, 4'h0, 1, 4'h8, 4'h8);
        add(1, 4'hF, 4'h9, 1, 4'h1, 1, 4'h1, 4'h1);
        add(1, 4'hF, 4'h0, 0, 4'h0, 1, 4'h1, 4'h1);
        add(0, 4'hF, 4'h0, 0, 4'h0, 0, 4'h0, 4'h0);
        add(1, 4'hF, 4'h0, 1, 4'h1, 1, 4'h1, 4'h0);

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].v, tbl[i].f, tbl[i].rdy, lanes_of(4'hF));
            check($sformatf("row%0d grant", i), grant, tbl[i].g);
            check($sformatf("row%0d stall", i), global_stall, tbl[i].st);
            tick();
            check($sformatf("row%0d out_valid", i), out_valid, tbl[i].ov);
            check($sformatf("row%0d out_flush", i), out_flush, tbl[i].of);
            check($sformatf("row%0d out_data", i), out_data, lanes_of(tbl[i].ov));
        end

        // single requester on channel 3 (pointer is at 1 here)
        d = '0; d[96 +: 32] = 32'hDEADBEEF;
        apply(1, 4'b1000, 4'h0, 1, d);
        check("single grant", grant, 4'b1000);
        check("single stall", global_stall, 1'b0);
        tick();
        check("single out_valid", out_valid, 4'b1000);
        check("single lane3", out_data, {32'hDEADBEEF, 96'h0});

        // held output lane survives input changes while out_ready is low
        d = '0; d[31:0] = 32'h1111_1111; d[63:32] = 32'h2222_2222;
        apply(1, 4'b0001, 4'h0, 1, d);
        check("hold grant0", grant, 4'b0001);
        tick();
        for (int unsigned i = 0; i < 4; i++) begin
            d[31:0] = $urandom;
            apply(1, 4'b0010, 4'h0, 0, d);
            check($sformatf("hold%0d grant", i), grant, 4'b0000);
            check($sformatf("hold%0d stall", i), global_stall, 1'b1);
            tick();
            check($sformatf("hold%0d out_data", i), out_data, 128'h1111_1111);
        end
        apply(1, 4'b0010, 4'h0, 1, d);
        check("release grant", grant, 4'b0010);
        tick();
        check("release out_data", out_data, {64'h0, 32'h2222_2222, 32'h0});

`ifdef SHARED_RES_STATS_EN
        apply(0, 4'h0, 4'h0, 1, '0);
        tick();
        check("stats reset stall", stall_cycles, '0);
        check("stats reset grants", grant_count, '0);
        for (int unsigned i = 0; i < 20; i++) begin
            apply(1, 4'hF, 4'h0, 1, lanes_of(4'hF));
            tick();
        end
        check("stall saturation", stall_cycles, 4'hF);
        check("grant counts", grant_count, {4'd5, 4'd5, 4'd5, 4'd5});
`endif

        // randomized run against the model
        apply(0, 4'h0, 4'h0, 1, '0);
        tick();
        model_reset();
        for (int unsigned n = 0; n < 1500; n++) begin
            rr   = ($urandom_range(0, 63) != 0);
            rv   = 4'($urandom_range(0, 15));
            rf   = 4'($urandom_range(0, 15));
            rrdy = ($urandom_range(0, 3) != 0);
            d    = {$urandom, $urandom, $urandom, $urandom};
            apply(rr, rv, rf, rrdy, d);
            acc = !m_has || rrdy;
            c   = (rr && acc) ? pick(rv, rf, m_ptr) : -1;
            eg  = (c >= 0) ? 4'(1 << c) : 4'h0;
            est = rr && (|(rv & ~eg));
            check($sformatf("rnd%0d grant", n), grant, eg);
            check($sformatf("rnd%0d stall", n), global_stall, est);
            tick();
            if (!rr) begin
                model_reset();
            end else begin
                if (acc) begin
                    if (c >= 0) begin
                        m_has  = 1;
                        m_ch   = c;
                        m_fl   = rf[c];
                        m_data = d[c*32 +: 32];
                        m_ptr  = (c + 1) % 4;
                        if (m_gcnt[c] < SAT) m_gcnt[c]++;
                    end else begin
                        m_has = 0;
                    end
                end
                if (est && m_stall < SAT) m_stall++;
            end
            check($sformatf("rnd%0d out_valid", n), out_valid, m_has ? 4'(1 << m_ch) : 4'h0);
            check($sformatf("rnd%0d out_flush", n), out_flush, (m_has && m_fl) ? 4'(1 << m_ch) : 4'h0);
            check($sformatf("rnd%0d out_data", n), out_data, m_has ? (128'(m_data) << (32 * m_ch)) : 128'h0);
`ifdef SHARED_RES_STATS_EN
            check($sformatf("rnd%0d stall_cycles", n), stall_cycles, 128'(m_stall));
            for (int unsigned k = 0; k < 4; k++)
                check($sformatf("rnd%0d grant_count%0d", n, k), grant_count[k*SW +: SW], 128'(m_gcnt[k]));
`endif
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
